// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences line-buffer priming/streaming and flags complete KSIZE x KSIZE windows
module line_buffer_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int KSIZE  = 3,
  parameter int CW     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             lb_rst,
  output logic [KSIZE-2:0] lb_wr_en,
  output logic [KSIZE-2:0] lb_rd_en,
  output logic             win_valid,
  output logic [CW-1:0]    win_col,
  output logic [CW-1:0]    win_row,
  output logic             busy,
  output logic             frame_done
);
  typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, DONE} state_t;
  localparam logic [CW-1:0] KM1 = CW'(KSIZE - 1);
  state_t state, state_nx;
  logic [CW-1:0] col, row;
  logic active, accept, abort_hit, abort_q, last_col, last_row;
  always_comb begin
    active    = state == FILL || state == RUN;
    abort_hit = abort && active;
    in_ready  = active && !abort;
    accept    = in_valid && in_ready;
    last_col  = col == CW'(WIDTH - 1);
    last_row  = row == CW'(HEIGHT - 1);
    // abort_q stretches the buffer clear into the IDLE cycle that follows an abort
    lb_rst     = !rst || state == CLEAR || abort_q;
    busy       = state != IDLE;
    frame_done = state == DONE;
    for (int k = 0; k < KSIZE - 1; k++) begin
      lb_wr_en[k] = accept && row >= CW'(k);
      lb_rd_en[k] = accept && row >= CW'(k + 1);
    end
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? CLEAR : IDLE;
      CLEAR: state_nx = FILL;
      FILL, RUN: begin
        if (abort_hit) state_nx = IDLE;
        else if (accept && last_col)
          state_nx = last_row ? DONE : (row == KM1 - 1'b1 ? RUN : state);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      abort_q   <= 1'b0;
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      state     <= state_nx;
      abort_q   <= abort_hit;
      win_valid <= accept && row >= KM1 && col >= KM1;
      if (accept) begin
        win_col <= col;
        win_row <= row;
        col     <= last_col ? '0 : col + 1'b1;
        row     <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      end
      if (state == CLEAR || abort_hit) begin
        col <= '0;
        row <= '0;
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: directed frame tests on 8x6 images with KSIZE=3 and KSIZE=5 instances in lockstep
module tb_line_buffer_ctrl;
  localparam int W = 8, H = 6, CW = 10;
  logic clk = 0, rst = 0, start = 0, abort = 0, in_valid = 0;
  logic in_ready, lb_rst, win_valid, busy, frame_done;
  logic [1:0] wr, rd;
  logic [CW-1:0] wc, wrow;
  logic in_ready5, lb_rst5, win_valid5, busy5, frame_done5;
  logic [3:0] wr5, rd5;
  logic [CW-1:0] wc5, wrow5;
  int checks = 0, failures = 0;
  int wins, wins5, first_win, first_win5;
  typedef struct {
    int p;
    logic [1:0] wr;
    logic [1:0] rd;
    logic wv;
    int wc;
    int wrow;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .KSIZE(3), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .lb_rst(lb_rst), .lb_wr_en(wr), .lb_rd_en(rd),
    .win_valid(win_valid), .win_col(wc), .win_row(wrow), .busy(busy), .frame_done(frame_done));

  line_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .KSIZE(5), .CW(CW)) dut5 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready5), .lb_rst(lb_rst5), .lb_wr_en(wr5), .lb_rd_en(rd5),
    .win_valid(win_valid5), .win_col(wc5), .win_row(wrow5), .busy(busy5), .frame_done(frame_done5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_win(input bit pa, input int pp);
    int r, c;
    r = pp / W;
    c = pp % W;
    chk("win_valid", win_valid, pa && r >= 2 && c >= 2);
    chk("win_valid5", win_valid5, pa && r >= 4 && c >= 4);
    if (pa) begin
      chk("win_col", wc, c);
      chk("win_row", wrow, r);
      chk("win_col5", wc5, c);
      chk("win_row5", wrow5, r);
      for (int i = 0; i < 10; i++)
        if (tbl[i].p == pp) begin
          chk("tbl_wv", win_valid, tbl[i].wv);
          chk("tbl_wc", wc, tbl[i].wc);
          chk("tbl_wrow", wrow, tbl[i].wrow);
        end
    end
    wins  += int'(win_valid);
    wins5 += int'(win_valid5);
    if (first_win < 0 && win_valid) first_win = pp;
    if (first_win5 < 0 && win_valid5) first_win5 = pp;
  endtask

  task automatic frame(input int gap, input int abort_at, input int rst_at, input bit poke);
    int p, prev_p, r, f_wr1, f_rd0, f_rd1, f_rd53;
    bit prev_acc, acc;
    logic [1:0] ewr, erd;
    logic [3:0] ewr5, erd5;
    p = 0; prev_p = 0; prev_acc = 0;
    wins = 0; wins5 = 0; first_win = -1; first_win5 = -1;
    f_wr1 = -1; f_rd0 = -1; f_rd1 = -1; f_rd53 = -1;
    start = 1;
    #1;
    chk("idle_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    cyc();
    start = 0;
    chk("clear_lb_rst", lb_rst, 1);
    chk("clear_busy", busy, 1);
    chk("clear_ready", in_ready, 0);
    cyc();
    chk("fill_lb_rst", lb_rst, 0);
    for (int c = 0; c < 400 && p < W * H; c++) begin
      check_win(prev_acc, prev_p);
      chk("frame_done_mid", frame_done, 0);
      if (p == rst_at) begin
        #2;
        rst = 0;
        #1;
        chk("arst_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_win_valid", win_valid, 0);
        chk("arst_lb_rst", lb_rst, 1);
        chk("arst_wr", wr, 0);
        chk("arst_rd", rd, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_win_col", wc, 0);
        chk("arst_win_row", wrow, 0);
        chk("arst_busy5", busy5, 0);
        cyc();
        cyc();
        rst = 1;
        in_valid = 0;
        cyc();
        chk("post_rst_lb_rst", lb_rst, 0);
        chk("post_rst_busy", busy, 0);
        return;
      end
      in_valid = $urandom_range(99) >= gap;
      abort = p == abort_at;
      start = poke && p == 30;
      #1;
      if (abort) begin
        chk("abort_ready", in_ready, 0);
        chk("abort_wr", wr, 0);
        chk("abort_rd", rd, 0);
        cyc();
        abort = 0;
        in_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_lb_rst", lb_rst, 1);
        chk("abort_done", frame_done, 0);
        chk("abort_win_valid", win_valid, 0);
        cyc();
        chk("abort_lb_rst_end", lb_rst, 0);
        chk("abort_done_end", frame_done, 0);
        chk("abort_busy_end", busy, 0);
        return;
      end
      chk("run_ready", in_ready, 1);
      chk("run_ready5", in_ready5, 1);
      acc = in_valid;
      r = p / W;
      ewr = acc ? {r >= 1, 1'b1} : 2'b00;
      erd = acc ? {r >= 2, r >= 1} : 2'b00;
      for (int k = 0; k < 4; k++) begin
        ewr5[k] = acc && r >= k;
        erd5[k] = acc && r >= k + 1;
      end
      chk("wr_en", wr, ewr);
      chk("rd_en", rd, erd);
      chk("wr_en5", wr5, ewr5);
      chk("rd_en5", rd5, erd5);
      for (int i = 0; i < 10; i++)
        if (acc && tbl[i].p == p) begin
          chk("tbl_wr", wr, tbl[i].wr);
          chk("tbl_rd", rd, tbl[i].rd);
        end
      if (f_wr1 < 0 && wr[1]) f_wr1 = p;
      if (f_rd0 < 0 && rd[0]) f_rd0 = p;
      if (f_rd1 < 0 && rd[1]) f_rd1 = p;
      if (f_rd53 < 0 && rd5[3]) f_rd53 = p;
      prev_acc = acc;
      prev_p = p;
      if (acc) p++;
      cyc();
      start = 0;
    end
    chk("pixel_timeout", p, W * H);
    in_valid = 0;
    check_win(prev_acc, prev_p);
    chk("done_pulse", frame_done, 1);
    chk("done_pulse5", frame_done5, 1);
    chk("done_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    start = poke;
    cyc();
    start = 0;
    chk("after_done", frame_done, 0);
    chk("after_busy", busy, 0);
    chk("after_lb_rst", lb_rst, 0);
    chk("after_win_valid", win_valid, 0);
    cyc();
    chk("still_idle", busy, 0);
    chk("win_count", wins, 24);
    chk("win_count5", wins5, 8);
    chk("first_wr1", f_wr1, 8);
    chk("first_rd0", f_rd0, 8);
    chk("first_rd1", f_rd1, 16);
    chk("first_rd5_3", f_rd53, 32);
    chk("first_win", first_win, 18);
    chk("first_win5", first_win5, 36);
  endtask

  initial begin
    tbl[0] = '{0,  2'b01, 2'b00, 1'b0, 0, 0};
    tbl[1] = '{7,  2'b01, 2'b00, 1'b0, 7, 0};
    tbl[2] = '{8,  2'b11, 2'b01, 1'b0, 0, 1};
    tbl[3] = '{16, 2'b11, 2'b11, 1'b0, 0, 2};
    tbl[4] = '{17, 2'b11, 2'b11, 1'b0, 1, 2};
    tbl[5] = '{18, 2'b11, 2'b11, 1'b1, 2, 2};
    tbl[6] = '{23, 2'b11, 2'b11, 1'b1, 7, 2};
    tbl[7] = '{24, 2'b11, 2'b11, 1'b0, 0, 3};
    tbl[8] = '{26, 2'b11, 2'b11, 1'b1, 2, 3};
    tbl[9] = '{47, 2'b11, 2'b11, 1'b1, 7, 5};
    #2;
    chk("rst_lb_rst", lb_rst, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 0);
    chk("rst_win_col", wc, 0);
    cyc();
    cyc();
    rst = 1;
    cyc();
    chk("rel_lb_rst", lb_rst, 0);
    frame(0, -1, -1, 1);
    frame(30, -1, -1, 0);
    frame(0, 21, -1, 0);
    frame(0, -1, -1, 0);
    frame(0, -1, 30, 0);
    frame(30, -1, -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
